// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
//   Bimodal branch history table of 2-bit saturating counters indexed by
//   pc[IDX_W+1:2]. Fetch asks for a prediction, execute sends back the
//   resolved outcome to train the table. Mispredictions are flagged for the
//   fetch unit to redirect, and saturating branch/mispredict counters are kept
//   for performance measurement.
//
// Ports
//   clk            in   1      clock, all state changes on posedge
//   rst_n          in   1      synchronous reset, active-low
//   pred_valid     in   1      prediction request this cycle
//   pred_pc        in   32     PC of the fetched instruction
//   pred_out_valid out  1      registered: pred_taken is valid
//   pred_taken     out  1      registered prediction (counter bit 1)
//   upd_valid      in   1      one conditional branch resolved this cycle
//   upd_pc         in   32     PC of the resolved branch
//   upd_taken      in   1      actual outcome
//   upd_pred       in   1      prediction carried with the branch
//   mispredict     out  1      registered one-cycle pulse on wrong prediction
//   br_count       out  CNT_W  resolved branches, saturating
//   mis_count      out  CNT_W  mispredictions, saturating
// -----------------------------------------------------------------------------
module branch_predictor_bht #(
   parameter int ENTRIES = 64,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pred_valid,
   input  logic [31:0]      pred_pc,
   output logic             pred_out_valid,
   output logic             pred_taken,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic             upd_pred,
   output logic             mispredict,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mis_count
);

   localparam int IDX_W = $clog2(ENTRIES);

   // 2-bit saturating counter step: taken counts up to 11, not-taken down to 00
   function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
      end else begin
         nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
      end
      return nxt;
   endfunction

   // Saturating +1 for the performance counters; holds at all-ones
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
      logic [CNT_W-1:0] nxt;
      if (inc && (cnt != {CNT_W{1'b1}})) begin
         nxt = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         nxt = cnt;
      end
      return nxt;
   endfunction

   logic [1:0]       table_q [ENTRIES];
   logic [1:0]       table_d [ENTRIES];
   logic             pred_out_valid_q, pred_out_valid_d;
   logic             pred_taken_q, pred_taken_d;
   logic             mispredict_q, mispredict_d;
   logic [CNT_W-1:0] br_count_q, br_count_d;
   logic [CNT_W-1:0] mis_count_q, mis_count_d;
   logic [IDX_W-1:0] pred_idx_s;
   logic [IDX_W-1:0] upd_idx_s;
   logic             upd_dir_s;

   // Bits outside the index field are intentionally ignored
   logic unused_pc_bits_s;
   assign unused_pc_bits_s = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                               upd_pc[31:IDX_W+2], upd_pc[1:0]};

   // Index/outcome gating: inputs are only looked at while their valid is high
   always_comb begin
      pred_idx_s = {IDX_W{1'b0}};
      upd_idx_s  = {IDX_W{1'b0}};
      upd_dir_s  = 1'b0;
      if (pred_valid) begin
         pred_idx_s = pred_pc[IDX_W+1:2];
      end else begin
         pred_idx_s = {IDX_W{1'b0}};
      end
      if (upd_valid) begin
         upd_idx_s = upd_pc[IDX_W+1:2];
         upd_dir_s = upd_taken;
      end else begin
         upd_idx_s = {IDX_W{1'b0}};
         upd_dir_s = 1'b0;
      end
   end

   // Table training and prediction; the lookup reads table_d so a same-cycle
   // update to the same entry is seen by the prediction (write-first)
   always_comb begin
      table_d          = table_q;
      pred_out_valid_d = pred_valid;
      pred_taken_d     = pred_taken_q;
      if (upd_valid) begin
         table_d[upd_idx_s] = sat_step(table_q[upd_idx_s], upd_dir_s);
      end else begin
         table_d = table_q;
      end
      if (pred_valid) begin
         pred_taken_d = table_d[pred_idx_s][1];
      end else begin
         pred_taken_d = pred_taken_q;
      end
   end

   // Mispredict flag and saturating performance counters
   always_comb begin
      mispredict_d = upd_valid & (upd_taken ^ upd_pred);
      br_count_d   = sat_inc(br_count_q, upd_valid);
      mis_count_d  = sat_inc(mis_count_q, mispredict_d);
   end

   // State registers with synchronous active-low reset; entries reset to weak-NT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= 2'b01;
         end
         pred_out_valid_q <= 1'b0;
         pred_taken_q     <= 1'b0;
         mispredict_q     <= 1'b0;
         br_count_q       <= {CNT_W{1'b0}};
         mis_count_q      <= {CNT_W{1'b0}};
      end else begin
         table_q          <= table_d;
         pred_out_valid_q <= pred_out_valid_d;
         pred_taken_q     <= pred_taken_d;
         mispredict_q     <= mispredict_d;
         br_count_q       <= br_count_d;
         mis_count_q      <= mis_count_d;
      end
   end

   assign pred_out_valid = pred_out_valid_q;
   assign pred_taken     = pred_taken_q;
   assign mispredict     = mispredict_q;
   assign br_count       = br_count_q;
   assign mis_count      = mis_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_bht
//   Self-checking bench for branch_predictor_bht (ENTRIES=64, CNT_W=4).
//   A behavioural model (integer array of counters, integer perf counters)
//   tracks the expected outputs; each test task compares inline.
// -----------------------------------------------------------------------------
module tb_branch_predictor_bht;

   localparam int ENTRIES = 64;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             pred_valid = 1'b0;
   logic [31:0]      pred_pc = 32'h0;
   logic             pred_out_valid;
   logic             pred_taken;
   logic             upd_valid = 1'b0;
   logic [31:0]      upd_pc = 32'h0;
   logic             upd_taken = 1'b0;
   logic             upd_pred = 1'b0;
   logic             mispredict;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] mis_count;

   int checks = 0;
   int failures = 0;

   // reference model state
   int m_tbl [ENTRIES];
   int exp_pov, exp_pt, exp_mis, exp_br, exp_misc;

   branch_predictor_bht #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .pred_valid(pred_valid), .pred_pc(pred_pc),
      .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
      .mispredict(mispredict), .br_count(br_count), .mis_count(mis_count)
   );

   always #5 clk = ~clk;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   // Advance one clock: fold the current inputs into the model, then step the DUT
   task automatic tick();
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 1;
         exp_pov = 0; exp_pt = 0; exp_mis = 0; exp_br = 0; exp_misc = 0;
      end else begin
         exp_mis = (upd_valid && (upd_taken != upd_pred)) ? 1 : 0;
         if (upd_valid) begin
            int u;
            u = idx_of(upd_pc);
            if (upd_taken) m_tbl[u] = (m_tbl[u] < 3) ? m_tbl[u] + 1 : 3;
            else           m_tbl[u] = (m_tbl[u] > 0) ? m_tbl[u] - 1 : 0;
            if (exp_br < CNT_MAX) exp_br++;
         end
         if (exp_mis == 1 && exp_misc < CNT_MAX) exp_misc++;
         exp_pov = pred_valid ? 1 : 0;
         if (pred_valid) exp_pt = (m_tbl[idx_of(pred_pc)] >= 2) ? 1 : 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pred_valid = 1'b0; upd_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (pred_out_valid !== 1'b0 || pred_taken !== 1'b0 || mispredict !== 1'b0 ||
          br_count !== 4'd0 || mis_count !== 4'd0) begin
         failures++;
         $display("FAIL reset: pov=%0b pt=%0b mis=%0b br=%0d misc=%0d, need all 0",
                  pred_out_valid, pred_taken, mispredict, br_count, mis_count);
      end
   endtask

   task automatic test_predict_basic();
      do_reset();
      pred_valid = 1'b1; pred_pc = 32'h100;
      tick();
      idle();
      checks++;
      if (pred_out_valid !== 1'b1 || pred_taken !== 1'b0) begin
         failures++;
         $display("FAIL predict_basic: pov=%0b pt=%0b, need 1/0", pred_out_valid, pred_taken);
      end
      tick();
      checks++;
      if (pred_out_valid !== 1'b0 || pred_taken !== 1'b0) begin
         failures++;
         $display("FAIL predict_hold: pov=%0b pt=%0b, need 0/0", pred_out_valid, pred_taken);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_pred = 1'b1;
         tick();
      end
      idle();
      pred_valid = 1'b1; pred_pc = 32'h100;
      tick();
      idle();
      checks++;
      if (pred_out_valid !== 1'b1 || pred_taken !== 1'b1) begin
         failures++;
         $display("FAIL saturate_taken: pov=%0b pt=%0b, need 1/1", pred_out_valid, pred_taken);
      end
      // one not-taken from 11 gives 10: still predicts taken
      upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b0; upd_pred = 1'b1;
      tick();
      idle();
      pred_valid = 1'b1; pred_pc = 32'h100;
      tick();
      idle();
      checks++;
      if (pred_taken !== 1'b1) begin
         failures++;
         $display("FAIL saturate_hysteresis: pt=%0b, need 1", pred_taken);
      end
   endtask

   task automatic test_alias();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_pred = 1'b0;
         tick();
      end
      idle();
      pred_valid = 1'b1; pred_pc = 32'h200;
      tick();
      checks++;
      if (pred_taken !== 1'b1) begin
         failures++;
         $display("FAIL alias_0x200: pt=%0b, need 1", pred_taken);
      end
      pred_pc = 32'h104;
      tick();
      idle();
      checks++;
      if (pred_taken !== 1'b0) begin
         failures++;
         $display("FAIL alias_0x104: pt=%0b, need 0", pred_taken);
      end
      pred_valid = 1'b1; pred_pc = 32'h103;   // low bits ignored -> index 0
      tick();
      idle();
      checks++;
      if (pred_taken !== 1'b1) begin
         failures++;
         $display("FAIL alias_lowbits: pt=%0b, need 1", pred_taken);
      end
   endtask

   task automatic test_collision();
      do_reset();
      upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_pred = 1'b0;
      pred_valid = 1'b1; pred_pc = 32'h100;
      tick();
      idle();
      checks++;
      if (pred_out_valid !== 1'b1 || pred_taken !== 1'b1) begin
         failures++;
         $display("FAIL collision_bypass: pov=%0b pt=%0b, need 1/1", pred_out_valid, pred_taken);
      end
   endtask

   task automatic test_mispredict();
      do_reset();
      upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b0; upd_pred = 1'b1;
      tick();
      checks++;
      if (mispredict !== 1'b1 || br_count !== 4'd1 || mis_count !== 4'd1) begin
         failures++;
         $display("FAIL mispredict_pulse: mis=%0b br=%0d misc=%0d, need 1/1/1",
                  mispredict, br_count, mis_count);
      end
      upd_taken = 1'b1; upd_pred = 1'b1;
      tick();
      idle();
      checks++;
      if (mispredict !== 1'b0 || br_count !== 4'd2 || mis_count !== 4'd1) begin
         failures++;
         $display("FAIL mispredict_match: mis=%0b br=%0d misc=%0d, need 0/2/1",
                  mispredict, br_count, mis_count);
      end
   endtask

   task automatic test_counter_saturation();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         upd_valid = 1'b1; upd_pc = 32'h8; upd_taken = i[0]; upd_pred = 1'b0;
         tick();
      end
      idle();
      checks++;
      if (br_count !== 4'd15 || mis_count !== 4'd8) begin
         failures++;
         $display("FAIL count_sat: br=%0d misc=%0d, need 15/8", br_count, mis_count);
      end
      for (int i = 0; i < 16; i++) begin
         upd_valid = 1'b1; upd_pc = 32'h8; upd_taken = 1'b1; upd_pred = 1'b0;
         tick();
      end
      idle();
      tick();
      checks++;
      if (br_count !== 4'd15 || mis_count !== 4'd15) begin
         failures++;
         $display("FAIL count_hold: br=%0d misc=%0d, need 15/15", br_count, mis_count);
      end
   endtask

   task automatic test_midstream_reset();
      do_reset();
      // train every entry to strong-taken
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < ENTRIES; i++) begin
            upd_valid = 1'b1; upd_pc = 32'(i * 4); upd_taken = 1'b1; upd_pred = 1'b0;
            tick();
         end
      end
      // reset with traffic in flight: both the update and the prediction are dropped
      upd_valid = 1'b1; upd_pc = 32'h0; upd_taken = 1'b1; upd_pred = 1'b0;
      pred_valid = 1'b1; pred_pc = 32'h0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      idle();
      checks++;
      if (pred_out_valid !== 1'b0 || mispredict !== 1'b0 || br_count !== 4'd0 ||
          mis_count !== 4'd0 || pred_taken !== 1'b0) begin
         failures++;
         $display("FAIL midreset_state: pov=%0b pt=%0b mis=%0b br=%0d misc=%0d, need all 0",
                  pred_out_valid, pred_taken, mispredict, br_count, mis_count);
      end
      for (int i = 0; i < ENTRIES; i++) begin
         pred_valid = 1'b1; pred_pc = 32'(i * 4);
         tick();
         checks++;
         if (pred_out_valid !== 1'b1 || pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL midreset_entry[%0d]: pov=%0b pt=%0b, need 1/0",
                     i, pred_out_valid, pred_taken);
         end
      end
      idle();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         pred_valid = ($urandom_range(0, 3) != 0);
         pred_pc    = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
         upd_valid  = ($urandom_range(0, 3) != 0);
         upd_pc     = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
         upd_taken  = $urandom_range(0, 1) == 1;
         upd_pred   = $urandom_range(0, 1) == 1;
         if (n == 300) begin
            rst_n = 1'b0;
         end else begin
            rst_n = 1'b1;
         end
         tick();
         checks++;
         if (pred_out_valid !== 1'(exp_pov) || pred_taken !== 1'(exp_pt) ||
             mispredict !== 1'(exp_mis) || br_count !== CNT_W'(exp_br) ||
             mis_count !== CNT_W'(exp_misc)) begin
            failures++;
            $display("FAIL random[%0d]: got pov=%0b pt=%0b mis=%0b br=%0d misc=%0d need %0d/%0d/%0d/%0d/%0d",
                     n, pred_out_valid, pred_taken, mispredict, br_count, mis_count,
                     exp_pov, exp_pt, exp_mis, exp_br, exp_misc);
         end
      end
      rst_n = 1'b1;
      idle();
   endtask

   initial begin
      for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 1;
      exp_pov = 0; exp_pt = 0; exp_mis = 0; exp_br = 0; exp_misc = 0;
      test_reset();
      test_predict_basic();
      test_saturate();
      test_alias();
      test_collision();
      test_mispredict();
      test_counter_saturation();
      test_midstream_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
